// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - MMIO map and status layout shared by the data memory responder
package data_mem_responder_pkg;

  localparam int MMIO_SEL_BIT = 31;

  typedef enum logic [1:0] {
    MMIO_GPIO      = 2'd0,
    MMIO_CYCLE     = 2'd1,
    MMIO_TX_DATA   = 2'd2,
    MMIO_TX_STATUS = 2'd3
  } mmio_reg_e;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_COUNT_LSB = 3;

endpackage

// File: rtl/data_mem_responder_sync_fifo.sv
// rtl/data_mem_responder_sync_fifo.sv - first-word fall-through FIFO with occupancy count
module data_mem_responder_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0]   DEPTH   = {1'b1, {AW{1'b0}}};
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  logic [WIDTH-1:0] mem [2**AW];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH);
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  // Storage is not reset; head is forced to zero while empty instead.
  assign head = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - core data port: word RAM plus GPIO, cycle counter and TX FIFO MMIO
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int RAM_AW  = 10,
  parameter int FIFO_AW = 3,
  parameter int GPIO_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic              mem_write,
  output logic [31:0]       mem_rdata,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  logic              is_mmio;
  mmio_reg_e         mmio_reg;
  logic [RAM_AW-1:0] ram_idx;
  logic              ram_we;
  logic              gpio_we;
  logic              tx_push;
  logic              ovf_clr;
  logic              unused_addr_bits;

  assign is_mmio  = mem_addr[MMIO_SEL_BIT];
  assign mmio_reg = mmio_reg_e'(mem_addr[3:2]);
  assign ram_idx  = mem_addr[RAM_AW+1:2];

  assign ram_we  = mem_write & ~is_mmio;
  assign gpio_we = mem_write & is_mmio & (mmio_reg == MMIO_GPIO);
  assign tx_push = mem_write & is_mmio & (mmio_reg == MMIO_TX_DATA);
  assign ovf_clr = mem_write & is_mmio & (mmio_reg == MMIO_TX_STATUS);

  assign unused_addr_bits = ^{mem_addr[30:RAM_AW+2], mem_addr[1:0]};

  // Read-first RAM with a registered output and no reset, so it maps onto block RAM.
  logic [31:0] ram [2**RAM_AW];
  logic [31:0] ram_q;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_idx] <= mem_wdata;
    end
    ram_q <= ram[ram_idx];
  end

  logic               tx_full;
  logic               tx_empty;
  logic [FIFO_AW:0]   tx_count;
  logic               tx_drop;

  data_mem_responder_sync_fifo #(
    .WIDTH (8),
    .AW    (FIFO_AW)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_push),
    .push_data (mem_wdata[7:0]),
    .pop       (tx_ready),
    .head      (tx_data),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  assign tx_valid = ~tx_empty;
  // A full FIFO is never empty, so tx_ready alone decides whether the head leaves.
  assign tx_drop  = tx_push & tx_full & ~tx_ready;

  logic [31:0] cycle_cnt;
  logic        tx_ovf;
  logic [31:0] status_word;
  logic [31:0] mmio_rd;
  logic [31:0] mmio_q;
  logic        rd_mmio_q;

  always_comb begin
    status_word = '0;
    status_word[ST_FULL]  = tx_full;
    status_word[ST_EMPTY] = tx_empty;
    status_word[ST_OVF]   = tx_ovf;
    status_word[ST_COUNT_LSB +: FIFO_AW+1] = tx_count;
  end

  always_comb begin
    mmio_rd = '0;
    case (mmio_reg)
      MMIO_GPIO:      mmio_rd = 32'(gpio_out);
      MMIO_CYCLE:     mmio_rd = cycle_cnt;
      MMIO_TX_DATA:   mmio_rd = '0;
      MMIO_TX_STATUS: mmio_rd = status_word;
      default:        mmio_rd = '0;
    endcase
  end

  // rd_mmio_q resets high so mem_rdata reads the zeroed MMIO register until the first load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mmio_q    <= '0;
      rd_mmio_q <= 1'b1;
      gpio_out  <= '0;
      cycle_cnt <= '0;
      tx_ovf    <= 1'b0;
    end else begin
      mmio_q    <= mmio_rd;
      rd_mmio_q <= is_mmio;
      cycle_cnt <= cycle_cnt + 32'd1;
      if (gpio_we) begin
        gpio_out <= mem_wdata[GPIO_W-1:0];
      end
      if (ovf_clr) begin
        tx_ovf <= 1'b0;
      end else if (tx_drop) begin
        tx_ovf <= 1'b1;
      end
    end
  end

  assign mem_rdata = rd_mmio_q ? mmio_q : ram_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;

  localparam logic [31:0] A_GPIO = 32'h8000_0000;
  localparam logic [31:0] A_CYC  = 32'h8000_0004;
  localparam logic [31:0] A_TX   = 32'h8000_0008;
  localparam logic [31:0] A_ST   = 32'h8000_000C;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic [7:0]  gpio_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int total = 0;
  int bad   = 0;

  data_mem_responder #(
    .RAM_AW  (10),
    .FIFO_AW (3),
    .GPIO_W  (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata),
    .gpio_out  (gpio_out),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    mem_addr  = a;
    mem_wdata = d;
    mem_write = 1'b1;
    tick();
    mem_write = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, output logic [31:0] d);
    mem_addr  = a;
    mem_write = 1'b0;
    tick();
    d = mem_rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] c1;
    logic [31:0] c2;

    reset     = 1'b1;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_write = 1'b0;
    tx_ready  = 1'b0;
    #12;
    check("rst_rdata", mem_rdata, 32'h0);
    check("rst_gpio", {24'h0, gpio_out}, 32'h0);
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    @(posedge clk);
    #2 reset = 1'b0;

    // RAM store/load and address aliasing
    do_store(32'h0000_0010, 32'hDEAD_BEEF);
    do_load(32'h0000_0010, rd);
    check("ram_load", rd, 32'hDEAD_BEEF);
    do_load(32'h0000_1010, rd);
    check("ram_alias", rd, 32'hDEAD_BEEF);

    // read-first on same-cycle store/load
    do_store(32'h0000_0020, 32'h5);
    mem_addr  = 32'h0000_0020;
    mem_wdata = 32'h1;
    mem_write = 1'b1;
    tick();
    mem_write = 1'b0;
    check("rdw_old", mem_rdata, 32'h5);
    do_load(32'h0000_0020, rd);
    check("rdw_new", rd, 32'h1);

    // GPIO and cycle counter
    do_store(A_GPIO, 32'h0000_00A5);
    check("gpio_out", {24'h0, gpio_out}, 32'hA5);
    do_load(A_GPIO, rd);
    check("gpio_load", rd, 32'hA5);
    do_store(A_GPIO, 32'hFFFF_FF5A);
    do_load(A_GPIO, rd);
    check("gpio_upper0", rd, 32'h5A);
    do_load(32'h8000_0010, rd);
    check("mmio_alias", rd, 32'h5A);
    do_load(A_CYC, c1);
    mem_addr = 32'h0;
    tick();
    tick();
    do_load(A_CYC, c2);
    check("cycle_delta", c2 - c1, 32'd3);

    // overflow: 9 pushes into an 8-deep FIFO with no drain
    for (int i = 1; i <= 9; i++) begin
      do_store(A_TX, i);
      if (i == 1) begin
        check("tx_first_valid", {31'h0, tx_valid}, 32'h1);
        check("tx_first_data", {24'h0, tx_data}, 32'h01);
      end
    end
    do_load(A_ST, rd);
    check("st_full_ovf", rd, 32'h45);
    do_load(A_TX, rd);
    check("txdata_reads0", rd, 32'h0);
    mem_addr = 32'h0;
    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("drain1_data%0d", i), {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, 8'(i)});
      tick();
    end
    check("drain1_empty", {31'h0, tx_valid}, 32'h0);
    do_load(A_ST, rd);
    check("st_empty_ovf", rd, 32'h06);
    do_store(A_ST, 32'h0);
    do_load(A_ST, rd);
    check("st_ovf_clr", rd, 32'h02);

    // push while full with a simultaneous pop
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) do_store(A_TX, 32'h11 + i);
    tx_ready = 1'b1;
    do_store(A_TX, 32'h55);
    tx_ready = 1'b0;
    do_load(A_ST, rd);
    check("st_full_noovf", rd, 32'h41);
    mem_addr = 32'h0;
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      c1 = (i == 7) ? 32'h155 : 32'h112 + i;
      check($sformatf("drain2_data%0d", i), {23'h0, tx_valid, tx_data}, c1);
      tick();
    end
    check("drain2_empty", {31'h0, tx_valid}, 32'h0);

    // sticky overflow cleared by a STATUS write
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) do_store(A_TX, 32'h21 + i);
    do_load(A_ST, rd);
    check("st_ovf_again", rd, 32'h45);
    do_store(A_ST, 32'hFFFF_FFFF);
    do_load(A_ST, rd);
    check("st_ovf_cleared", rd, 32'h41);

    // asynchronous reset with a drain in progress
    mem_addr = A_GPIO;
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("mid_tx_data", {23'h0, tx_valid, tx_data}, 32'h125);
    check("mid_rdata", mem_rdata, 32'h5A);
    #2 reset = 1'b1;
    #1;
    check("arst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("arst_tx_data", {24'h0, tx_data}, 32'h0);
    check("arst_gpio", {24'h0, gpio_out}, 32'h0);
    check("arst_rdata", mem_rdata, 32'h0);
    mem_addr = A_CYC;
    #2 reset = 1'b0;
    tick();
    check("post_cycle0", mem_rdata, 32'h0);
    tick();
    check("post_cycle1", mem_rdata, 32'h1);
    do_load(A_ST, rd);
    check("post_st_empty", rd, 32'h02);
    do_load(32'h0000_0010, rd);
    check("ram_kept", rd, 32'hDEAD_BEEF);

    // push and pop attempted together on an empty FIFO
    do_store(A_TX, 32'h77);
    check("empty_pushpop", {23'h0, tx_valid, tx_data}, 32'h177);
    mem_addr = 32'h0;
    tick();
    check("empty_pushpop_drain", {31'h0, tx_valid}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
